// File: rtl/div_seq.sv
// div_seq: 32-bit multi-cycle restoring divider (DIV/DIVU) for the MIPS execute stage.
//   clk, rst (async, active-high); start/signed_div/opdata1/opdata2 launch a divide,
//   annul cancels it; result = {remainder, quotient} valid while ready; stall_req holds the pipeline.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_req
);
  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;
  state_t state, state_n;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dvs, rem_n, quo_n;
  logic        sgn_q, sgn_r;
  logic [32:0] trial;
  // The shifted partial remainder keeps the bit shifted out of rem, so divisors above 2^31 stay exact.
  always_comb begin
    trial = {rem, quo[31]} - {1'b0, dvs};
    rem_n = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
    quo_n = {quo[30:0], ~trial[32]};
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = !start ? S_IDLE : opdata2 == 32'd0 ? S_BYZERO : S_ON;
      S_BYZERO: state_n = S_END;
      S_ON:     state_n = cnt == 5'd31 ? S_END : S_ON;
      S_END:    state_n = start ? S_END : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (annul) state_n = S_IDLE;
  end
  assign ready     = state == S_END;
  assign stall_req = start & ~ready & ~annul;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (annul) begin
        result <= '0;
        cnt    <= '0;
      end else case (state)
        S_IDLE: if (start && opdata2 != 32'd0) begin
          rem   <= '0;
          quo   <= signed_div && opdata1[31] ? -opdata1 : opdata1;
          dvs   <= signed_div && opdata2[31] ? -opdata2 : opdata2;
          sgn_q <= signed_div && (opdata1[31] ^ opdata2[31]);
          sgn_r <= signed_div && opdata1[31];
          cnt   <= '0;
        end
        S_BYZERO: result <= '0;
        S_ON: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) result <= {sgn_r ? -rem_n : rem_n, sgn_q ? -quo_n : quo_n};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq using directed vectors and corner sequences.
module tb_div_seq;
  logic        clk = 0, rst = 1, start = 0, signed_div = 0, annul = 0;
  logic [31:0] opdata1 = 0, opdata2 = 0;
  logic [63:0] result;
  logic        ready, stall_req;
  int checks = 0, fails = 0;

  div_seq dut (.clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
               .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready), .stall_req(stall_req));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] r;
    int          c;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] er, input int ec, input string nm);
    int n;
    logic st_ok;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; start = 1;
    #1;
    n = 0; st_ok = 1;
    while (n < 40) begin
      if (stall_req !== 1'b1) st_ok = 0;
      @(posedge clk); #1;
      n++;
      if (n == 1) begin opdata1 = ~a; opdata2 = 32'd0; signed_div = ~s; end
      if (ready) break;
    end
    chk({nm, " cycles"}, 64'(n), 64'(ec));
    chk({nm, " result"}, result, er);
    chk({nm, " stall_before"}, 64'(st_ok), 64'd1);
    chk({nm, " stall_at_ready"}, 64'(stall_req), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " hold_ready"}, 64'(ready), 64'd1);
    chk({nm, " hold_result"}, result, er);
    @(negedge clk);
    start = 0;
    @(posedge clk); #1;
    chk({nm, " idle_after"}, 64'(ready), 64'd0);
  endtask

  initial begin
    v[0]  = '{32'd100,        32'd7,          1'b0, {32'h00000002, 32'h0000000E}, 33};
    v[1]  = '{32'hFFFFFFF9,   32'h00000002,   1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
    v[2]  = '{32'hFFFFFFF9,   32'h00000002,   1'b0, {32'h00000001, 32'h7FFFFFFC}, 33};
    v[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h00000000, 32'h80000000}, 33};
    v[4]  = '{32'h80000000,   32'h00000001,   1'b1, {32'h00000000, 32'h80000000}, 33};
    v[5]  = '{32'd5,          32'd0,          1'b0, 64'd0,                        2};
    v[6]  = '{32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0, {32'h00000001, 32'h00000001}, 33};
    v[7]  = '{32'd7,          32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD}, 33};
    v[8]  = '{32'hFFFFFFF8,   32'hFFFFFFFD,   1'b1, {32'hFFFFFFFE, 32'h00000002}, 33};
    v[9]  = '{32'hFFFFFFFF,   32'h00000001,   1'b0, {32'h00000000, 32'hFFFFFFFF}, 33};
    v[10] = '{32'd12345,      32'd0,          1'b1, 64'd0,                        2};

    start = 1;
    #12;
    chk("reset result", result, 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset stall", 64'(stall_req), 64'd1);
    @(negedge clk);
    start = 0; rst = 0;

    for (int i = 0; i < 11; i++) run_div(v[i].a, v[i].b, v[i].s, v[i].r, v[i].c, $sformatf("vec%0d", i));

    // annul during iteration 10, then a fresh 9/3
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 0; start = 1;
    repeat (10) @(negedge clk);
    annul = 1;
    #1;
    chk("annul stall", 64'(stall_req), 64'd0);
    begin
      logic rdy_seen;
      rdy_seen = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (ready) rdy_seen = 1;
      end
      chk("annul no_ready", 64'(rdy_seen), 64'd0);
      chk("annul result", result, 64'd0);
    end
    @(negedge clk);
    annul = 0; start = 0;
    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "after_annul");

    // asynchronous reset mid-division
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 0; start = 1;
    repeat (20) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst result", result, 64'd0);
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst stall", 64'(stall_req), 64'd1);
    @(negedge clk);
    rst = 0; start = 0;
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
